// File: rtl/npg_pulse_sequencer_pkg.sv
// Shared definitions for the NPG pulse sequencer: state encodings and default sizing.
package npg_pulse_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PH1  = 3'd1,
        ST_GAP  = 3'd2,
        ST_PH2  = 3'd3,
        ST_REST = 3'd4
    } state_t;

    localparam int CLK_DIV_DEF = 1250;
    localparam int DAC_W_DEF   = 6;
    localparam int NSW_DEF     = 3;
    localparam int TW_DEF      = 16;

endpackage

// File: rtl/npg_tick_gen.sv
// Divides the system clock down to the 20 kHz sequencing tick and a square-wave copy of it.
module npg_tick_gen
    import npg_pulse_sequencer_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic clk,
    input  logic reset,
    output logic tick,
    output logic clk_20khz
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] HALF = DW'(CLK_DIV / 2);

    logic [DW-1:0] div_q, div_d;
    logic          clk_q, clk_d;

    always_comb begin
        div_d = (div_q == LAST) ? '0 : div_q + 1'b1;
        // Registered from the next divider value so the square wave tracks div_q exactly.
        clk_d = (div_d < HALF);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q <= '0;
            clk_q <= 1'b0;
        end else begin
            div_q <= div_d;
            clk_q <= clk_d;
        end
    end

    assign tick      = (div_q == LAST);
    assign clk_20khz = clk_q;

endmodule

// File: rtl/npg_pulse_sequencer.sv
// Biphasic charge-balanced pulse train sequencer for the NPG output stage.
//  state | meaning
//  IDLE  | waiting for enable on a tick, outputs off
//  PH1   | first phase, polarity from shadow pol
//  GAP   | interphase gap, switches open
//  PH2   | second (balancing) phase, opposite direction
//  REST  | inter-pulse rest, decides stop / repeat
module npg_pulse_sequencer
    import npg_pulse_sequencer_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF,
    parameter int DAC_W   = DAC_W_DEF,
    parameter int NSW     = NSW_DEF,
    parameter int TW      = TW_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [DAC_W-1:0] cfg_amp,
    input  logic [NSW-1:0]   cfg_sel,
    input  logic             cfg_pol,
    input  logic [TW-1:0]    cfg_phase,
    input  logic [TW-1:0]    cfg_gap,
    input  logic [TW-1:0]    cfg_rest,
    input  logic [7:0]       cfg_count,
    output logic             clk_20khz,
    output logic [NSW-1:0]   up_switches,
    output logic [NSW-1:0]   down_switches,
    output logic [DAC_W-1:0] dac,
    output logic             pulse_active,
    output logic             busy,
    output logic             done
);

    function automatic logic [TW-1:0] width_m1(input logic [TW-1:0] w);
        return (w == '0) ? '0 : w - 1'b1;
    endfunction

    logic tick;

    npg_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .clk_20khz (clk_20khz)
    );

    state_t           state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             start;

    logic [DAC_W-1:0] sh_amp_q, sh_amp_d;
    logic [NSW-1:0]   sh_sel_q, sh_sel_d;
    logic             sh_pol_q, sh_pol_d;
    logic [TW-1:0]    sh_phase_q, sh_phase_d;
    logic [TW-1:0]    sh_gap_q, sh_gap_d;
    logic [TW-1:0]    sh_rest_q, sh_rest_d;
    logic [7:0]       sh_count_q, sh_count_d;

    logic [NSW-1:0]   up_q, up_d, down_q, down_d;
    logic [DAC_W-1:0] dac_q, dac_d;
    logic             pa_q, pa_d, busy_q, busy_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            sh_amp_q   <= '0;
            sh_sel_q   <= '0;
            sh_pol_q   <= 1'b0;
            sh_phase_q <= '0;
            sh_gap_q   <= '0;
            sh_rest_q  <= '0;
            sh_count_q <= '0;
            up_q       <= '0;
            down_q     <= '0;
            dac_q      <= '0;
            pa_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            sh_amp_q   <= sh_amp_d;
            sh_sel_q   <= sh_sel_d;
            sh_pol_q   <= sh_pol_d;
            sh_phase_q <= sh_phase_d;
            sh_gap_q   <= sh_gap_d;
            sh_rest_q  <= sh_rest_d;
            sh_count_q <= sh_count_d;
            up_q       <= up_d;
            down_q     <= down_d;
            dac_q      <= dac_d;
            pa_q       <= pa_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        cnt_d      = cnt_q;
        done_d     = done_q;
        start      = 1'b0;
        sh_amp_d   = sh_amp_q;
        sh_sel_d   = sh_sel_q;
        sh_pol_d   = sh_pol_q;
        sh_phase_d = sh_phase_q;
        sh_gap_d   = sh_gap_q;
        sh_rest_d  = sh_rest_q;
        sh_count_d = sh_count_q;

        case (state_q)
            ST_IDLE: begin
                if (!enable) done_d = 1'b0;
                if (tick && enable && !done_q) begin
                    state_d = ST_PH1;
                    start   = 1'b1;
                    cnt_d   = '0;
                end
            end
            ST_PH1: if (tick) begin
                if (timer_q == '0) begin
                    state_d = ST_GAP;
                    timer_d = width_m1(sh_gap_q);
                end else timer_d = timer_q - 1'b1;
            end
            ST_GAP: begin
                // Zero gap still opens all switches for one clock, then PH2 counts a full width from the next tick.
                if (sh_gap_q == '0) begin
                    state_d = ST_PH2;
                    timer_d = (sh_phase_q == '0) ? TW'(1) : sh_phase_q;
                end else if (tick) begin
                    if (timer_q == '0) begin
                        state_d = ST_PH2;
                        timer_d = width_m1(sh_phase_q);
                    end else timer_d = timer_q - 1'b1;
                end
            end
            ST_PH2: if (tick) begin
                if (timer_q == '0) begin
                    state_d = ST_REST;
                    timer_d = width_m1(sh_rest_q);
                    cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                end else timer_d = timer_q - 1'b1;
            end
            ST_REST: if (tick) begin
                if (timer_q == '0) begin
                    if ((sh_count_q != 8'd0) && (cnt_q == sh_count_q)) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else if (enable) begin
                        state_d = ST_PH1;
                        start   = 1'b1;
                    end else state_d = ST_IDLE;
                end else timer_d = timer_q - 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        if (start) begin
            sh_amp_d   = cfg_amp;
            sh_sel_d   = cfg_sel;
            sh_pol_d   = cfg_pol;
            sh_phase_d = cfg_phase;
            sh_gap_d   = cfg_gap;
            sh_rest_d  = cfg_rest;
            sh_count_d = cfg_count;
            timer_d    = width_m1(cfg_phase);
        end
    end

    always_comb begin
        up_d   = '0;
        down_d = '0;
        dac_d  = '0;
        case (state_d)
            ST_PH1: begin
                if (sh_pol_d) up_d = sh_sel_d;
                else          down_d = sh_sel_d;
                dac_d = sh_amp_d;
            end
            ST_PH2: begin
                if (sh_pol_d) down_d = sh_sel_d;
                else          up_d = sh_sel_d;
                dac_d = sh_amp_d;
            end
            default: ;
        endcase
        pa_d   = (state_d == ST_PH1) || (state_d == ST_GAP) || (state_d == ST_PH2);
        busy_d = (state_d != ST_IDLE);
    end

    assign up_switches   = up_q;
    assign down_switches = down_q;
    assign dac           = dac_q;
    assign pulse_active  = pa_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule
